dlx_pipe_if: RTL and testbench

Instruction-fetch stage of the 5-stage DLX pipeline. Owns the program counter and drives the instruction-memory port. Loads the IF/ID pipe register (`if_id_npc`, `if_id_ir`) that feeds instruction decode. Consumes the branch, trap and illegal-instruction controls that decode produces, and runs a small halt/drain state machine that stops fetching cleanly.

---
 rtl/dlx_global_pkg.sv | 9 +
 rtl/dlx_if_halt_ctrl.sv | 42 ++++
 rtl/dlx_pipe_if.sv | 66 ++++++
 tb/tb_dlx_pipe_if.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dlx_global_pkg.sv
// dlx_global_pkg: shared DLX word type, NOP encoding, IF halt-FSM states and drain default
package dlx_global_pkg;
  typedef logic [31:0] dlx_word;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] SP_NOP = 6'h00;
  localparam dlx_word IR_NOP = {OP_SPECIAL, 20'h0, SP_NOP};
  localparam int DRAIN_CYCLES_DEF = 3;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} if_state_e;
endpackage

// File: rtl/dlx_if_halt_ctrl.sv
// dlx_if_halt_ctrl: run/drain/halted FSM with drain counter; in clk,rst,dc_wait,stall,id_halt,id_illegal_instr; out fetch_en,if_halted,if_exc
module dlx_if_halt_ctrl
  import dlx_global_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dc_wait,
  input  logic stall,
  input  logic id_halt,
  input  logic id_illegal_instr,
  output logic fetch_en,
  output logic if_halted,
  output logic if_exc
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  if_state_e state;
  logic [CW-1:0] drain_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      drain_cnt <= '0;
      fetch_en <= 1'b1;
      if_halted <= 1'b0;
      if_exc <= 1'b0;
    end else if (!dc_wait) begin
      if (state == RUN && (id_halt || id_illegal_instr) && !stall) begin
        state <= DRAIN;
        drain_cnt <= CW'(DRAIN_CYCLES);
        fetch_en <= 1'b0;
        if_exc <= id_illegal_instr;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - CW'(1);
        if (drain_cnt == CW'(1)) begin
          state <= HALTED;
          if_halted <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dlx_pipe_if.sv
// dlx_pipe_if: DLX fetch stage; PC, IM port (im_adr,im_en,im_data,im_wait), IF/ID reg (if_id_npc,if_id_ir), controls (stall,dc_wait,id_cond,id_npc,id_halt,id_illegal_instr), status (if_halted,if_exc)
module dlx_pipe_if
  import dlx_global_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic dc_wait,
  input  logic id_cond,
  input  logic [31:0] id_npc,
  input  logic id_halt,
  input  logic id_illegal_instr,
  output logic [31:0] im_adr,
  output logic im_en,
  input  logic [31:0] im_data,
  input  logic im_wait,
  output logic [31:0] if_id_npc,
  output logic [31:0] if_id_ir,
  output logic if_halted,
  output logic if_exc
);
  dlx_word pc;
  dlx_word pc_inc;
  logic fetch_en;
  logic halt_go;
  dlx_if_halt_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_halt (
    .clk(clk),
    .rst(rst),
    .dc_wait(dc_wait),
    .stall(stall),
    .id_halt(id_halt),
    .id_illegal_instr(id_illegal_instr),
    .fetch_en(fetch_en),
    .if_halted(if_halted),
    .if_exc(if_exc)
  );
  assign im_adr = pc & ~32'h3;
  assign im_en = fetch_en;
  assign pc_inc = pc + 32'd4;
  assign halt_go = fetch_en && (id_halt || id_illegal_instr) && !stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      if_id_ir <= IR_NOP;
      if_id_npc <= '0;
    end else if (!dc_wait) begin
      if (!fetch_en || halt_go) begin
        if_id_ir <= IR_NOP;
      end else if (!stall) begin
        if (id_cond) begin
          pc <= id_npc & ~32'h3;
          if_id_ir <= IR_NOP;
        end else if (im_wait) begin
          if_id_ir <= IR_NOP;
        end else begin
          pc <= pc_inc;
          if_id_ir <= im_data;
          if_id_npc <= pc_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_dlx_pipe_if.sv
// tb_dlx_pipe_if: directed self-checking bench for the DLX fetch stage
module tb_dlx_pipe_if;
  logic clk = 1'b0;
  logic rst, stall, dc_wait, id_cond, id_halt, id_illegal_instr, im_wait;
  logic [31:0] id_npc, im_adr, im_data, if_id_npc, if_id_ir;
  logic im_en, if_halted, if_exc;
  int total = 0;
  int bad = 0;
  localparam logic [31:0] NOP = 32'h0000_0000;
  always #5 clk = ~clk;
  assign im_data = 32'h1000_0000 + im_adr;
  dlx_pipe_if dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .dc_wait(dc_wait),
    .id_cond(id_cond),
    .id_npc(id_npc),
    .id_halt(id_halt),
    .id_illegal_instr(id_illegal_instr),
    .im_adr(im_adr),
    .im_en(im_en),
    .im_data(im_data),
    .im_wait(im_wait),
    .if_id_npc(if_id_npc),
    .if_id_ir(if_id_ir),
    .if_halted(if_halted),
    .if_exc(if_exc)
  );
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; stall = 0; dc_wait = 0; id_cond = 0; id_npc = 0;
    id_halt = 0; id_illegal_instr = 0; im_wait = 0;
    step();
    dc_wait = 1;
    step();
    rst = 0; dc_wait = 0;
    chk("rst_adr", im_adr, 32'h0);
    chk("rst_en", {31'b0, im_en}, 32'h1);
    chk("rst_ir", if_id_ir, NOP);
    chk("rst_npc", if_id_npc, 32'h0);
    chk("rst_halted", {31'b0, if_halted}, 32'h0);
    chk("rst_exc", {31'b0, if_exc}, 32'h0);
    step();
    chk("seq1_adr", im_adr, 32'h4);
    chk("seq1_ir", if_id_ir, 32'h1000_0000);
    chk("seq1_npc", if_id_npc, 32'h4);
    step();
    chk("seq2_adr", im_adr, 32'h8);
    chk("seq2_ir", if_id_ir, 32'h1000_0004);
    chk("seq2_npc", if_id_npc, 32'h8);
    stall = 1;
    step();
    step();
    chk("stall_adr", im_adr, 32'h8);
    chk("stall_ir", if_id_ir, 32'h1000_0004);
    chk("stall_npc", if_id_npc, 32'h8);
    id_cond = 1; id_npc = 32'h200;
    step();
    chk("stall_cond_adr", im_adr, 32'h8);
    chk("stall_cond_ir", if_id_ir, 32'h1000_0004);
    stall = 0; id_cond = 0; im_wait = 1;
    step();
    chk("wait1_adr", im_adr, 32'h8);
    chk("wait1_ir", if_id_ir, NOP);
    step();
    chk("wait2_adr", im_adr, 32'h8);
    chk("wait2_ir", if_id_ir, NOP);
    im_wait = 0;
    step();
    chk("resume_adr", im_adr, 32'hC);
    chk("resume_ir", if_id_ir, 32'h1000_0008);
    chk("resume_npc", if_id_npc, 32'hC);
    repeat (5) step();
    chk("pre_br_adr", im_adr, 32'h20);
    id_cond = 1; id_npc = 32'h0000_0103;
    step();
    chk("br_adr", im_adr, 32'h100);
    chk("br_squash_ir", if_id_ir, NOP);
    id_cond = 0;
    step();
    chk("br_tgt_ir", if_id_ir, 32'h1000_0100);
    chk("br_tgt_npc", if_id_npc, 32'h104);
    chk("br_next_adr", im_adr, 32'h104);
    id_cond = 1; id_npc = 32'hFFFF_FFFF;
    step();
    chk("wrap_pre_adr", im_adr, 32'hFFFF_FFFC);
    id_cond = 0;
    step();
    chk("wrap_adr", im_adr, 32'h0);
    chk("wrap_npc", if_id_npc, 32'h0);
    chk("wrap_ir", if_id_ir, 32'h0FFF_FFFC);
    dc_wait = 1;
    step();
    chk("dcw_run_adr", im_adr, 32'h0);
    chk("dcw_run_ir", if_id_ir, 32'h0FFF_FFFC);
    dc_wait = 0; id_halt = 1;
    step();
    id_halt = 0;
    chk("trap_en", {31'b0, im_en}, 32'h0);
    chk("trap_ir", if_id_ir, NOP);
    chk("trap_adr", im_adr, 32'h0);
    chk("trap_halted", {31'b0, if_halted}, 32'h0);
    step();
    dc_wait = 1;
    step();
    step();
    step();
    chk("dcw_drain_halted", {31'b0, if_halted}, 32'h0);
    chk("dcw_drain_en", {31'b0, im_en}, 32'h0);
    dc_wait = 0;
    step();
    chk("drain_last_halted", {31'b0, if_halted}, 32'h0);
    step();
    chk("trap_halted_on", {31'b0, if_halted}, 32'h1);
    chk("trap_exc", {31'b0, if_exc}, 32'h0);
    rst = 1;
    step();
    rst = 0;
    chk("rst2_en", {31'b0, im_en}, 32'h1);
    chk("rst2_halted", {31'b0, if_halted}, 32'h0);
    step();
    step();
    chk("pre_ill_adr", im_adr, 32'h8);
    id_illegal_instr = 1; id_cond = 1; id_npc = 32'h40;
    step();
    id_illegal_instr = 0; id_cond = 0;
    chk("ill_en", {31'b0, im_en}, 32'h0);
    chk("ill_adr", im_adr, 32'h8);
    chk("ill_ir", if_id_ir, NOP);
    step();
    step();
    chk("ill_n3_halted", {31'b0, if_halted}, 32'h0);
    step();
    chk("ill_halted", {31'b0, if_halted}, 32'h1);
    chk("ill_exc", {31'b0, if_exc}, 32'h1);
    id_cond = 1; id_npc = 32'h80;
    step();
    id_cond = 0;
    chk("halted_cond_adr", im_adr, 32'h8);
    chk("halted_cond_en", {31'b0, im_en}, 32'h0);
    chk("halted_ir", if_id_ir, NOP);
    rst = 1; dc_wait = 1;
    step();
    rst = 0; dc_wait = 0;
    chk("rst3_adr", im_adr, 32'h0);
    chk("rst3_halted", {31'b0, if_halted}, 32'h0);
    chk("rst3_exc", {31'b0, if_exc}, 32'h0);
    chk("rst3_en", {31'b0, im_en}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
